ifu_lsu_rd_arbiter: RTL

//  Two-master AXI4 read-channel arbiter that shares the single memory read port between the ICache refill

---
 rtl/ifu_lsu_rd_arbiter_if.sv | 32 +++
 rtl/ifu_lsu_rd_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ifu_lsu_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) shared by the IFU/LSU masters and the memory port.
// The master modport drives AR and RREADY; the slave modport drives ARREADY and the R beat.
interface ifu_lsu_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [ID_W-1:0]   arid;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/ifu_lsu_rd_arbiter.sv
// Two-master AXI4 read arbiter (m0 = IFU refill, m1 = LSU load) onto one memory read port, one burst in flight.
// Define ARB_RR_EN for round-robin on simultaneous requests; otherwise m1 has fixed priority over m0.
module ifu_lsu_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  ifu_lsu_rd_arbiter_if.slave   m0,
  ifu_lsu_rd_arbiter_if.slave   m1,
  ifu_lsu_rd_arbiter_if.master  s
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]        state_q,   state_d;
  logic              gnt_q,     gnt_d;
  logic              lgnt_q,    lgnt_d;
  logic [ADDR_W-1:0] araddr_q,  araddr_d;
  logic [7:0]        arlen_q,   arlen_d;
  logic [2:0]        arsize_q,  arsize_d;
  logic [1:0]        arburst_q, arburst_d;
  logic [ID_W-1:0]   arid_q,    arid_d;

  logic              in_idle;
  logic              in_addr;
  logic              in_data;
  logic              any_req;
  logic              winner;
  logic              accept;
  logic              s_rready;
  logic              r_done;
  logic [DATA_W-1:0] r_data;
  logic [ID_W-1:0]   r_id;

  assign in_idle = (state_q == ST_IDLE);
  assign in_addr = (state_q == ST_ADDR);
  assign in_data = (state_q == ST_DATA);
  assign any_req = m0.arvalid | m1.arvalid;

  // winner is only meaningful while a request is present; it selects m1 when high
  always_comb begin
`ifdef ARB_RR_EN
    winner = (m0.arvalid & m1.arvalid) ? ~lgnt_q : m1.arvalid;
`else
    winner = m1.arvalid;
`endif
  end

  assign accept = ~reset & in_idle & any_req;

  // AR side: only the IDLE winner sees arready, memory sees the latched request in ADDR
  assign m0.arready = accept & ~winner;
  assign m1.arready = accept &  winner;

  assign s.arvalid  = ~reset & in_addr;
  assign s.araddr   = araddr_q;
  assign s.arlen    = arlen_q;
  assign s.arsize   = arsize_q;
  assign s.arburst  = arburst_q;
  assign s.arid     = arid_q;

  // R side: only rvalid/rready are steered by the grant; beat fields fan out to both masters
  assign s_rready  = ~reset & in_data & (gnt_q ? m1.rready : m0.rready);
  assign s.rready  = s_rready;
  assign m0.rvalid = ~reset & in_data & s.rvalid & ~gnt_q;
  assign m1.rvalid = ~reset & in_data & s.rvalid &  gnt_q;
  assign r_done    = in_data & s.rvalid & s_rready & s.rlast;

  assign r_data    = s.rdata;
  assign r_id      = s.rid;
  assign m0.rdata  = r_data;
  assign m1.rdata  = r_data;
  assign m0.rresp  = s.rresp;
  assign m1.rresp  = s.rresp;
  assign m0.rlast  = s.rlast;
  assign m1.rlast  = s.rlast;
  assign m0.rid    = r_id;
  assign m1.rid    = r_id;

  // NOTE: every always_comb output takes its hold value first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    lgnt_d    = lgnt_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    arid_d    = arid_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_ADDR;
          gnt_d     = winner;
          lgnt_d    = winner;
          araddr_d  = winner ? m1.araddr  : m0.araddr;
          arlen_d   = winner ? m1.arlen   : m0.arlen;
          arsize_d  = winner ? m1.arsize  : m0.arsize;
          arburst_d = winner ? m1.arburst : m0.arburst;
          arid_d    = winner ? m1.arid    : m0.arid;
        end
      end
      ST_ADDR: begin
        if (s.arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        // beat count is not tracked; the slave's rlast alone closes the burst
        if (r_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and active-high here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      lgnt_q    <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      arid_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      lgnt_q    <= lgnt_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      arid_q    <= arid_d;
    end
  end

endmodule
